// File: rtl/pwm_pkg.sv
// pwm_pkg: shared channel mode and breathe direction types for the Pmod PWM LED samples
package pwm_pkg;
    typedef enum logic {PWM_STATIC, PWM_BREATHE} pwm_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one-cycle tick every PRESCALE clocks; ports: clk, rst (sync, active-high) in, tick out
module pwm_prescaler #(
    parameter int PRESCALE = 2700
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] presc_cnt;
    assign tick = presc_cnt == W'(PRESCALE - 1);
    always_ff @(posedge clk)
        if (rst) presc_cnt <= '0;
        else presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
endmodule

// File: rtl/pwm_led_driver.sv
// pwm_led_driver: N-channel static/breathing PWM LED driver; ports: clk, rst, cfg_wr/cfg_ch/cfg_mode/cfg_duty config in, led, period_start out
module pwm_led_driver
    import pwm_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int RES_BITS    = 8,
    parameter int PRESCALE    = 2700,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_wr,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic                                cfg_mode,
    input  logic [RES_BITS-1:0]                 cfg_duty,
    output logic [NUM_CH-1:0]                   led,
    output logic                                period_start
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [RES_BITS-1:0] MAX = '1;
    localparam logic [NUM_CH-1:0] OFF = {NUM_CH{ACTIVE_HIGH == 0}};
    logic tick, boundary;
    logic [RES_BITS-1:0] pwm_cnt;
    logic [NUM_CH-1:0] on;
    pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );
    assign boundary = tick && pwm_cnt == MAX;
    always_ff @(posedge clk)
        if (rst) begin
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            led          <= OFF;
        end else begin
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            period_start <= boundary;
            led          <= on ^ OFF;
        end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [RES_BITS-1:0] sh_duty, level;
        pwm_mode_e sh_mode, mode;
        pwm_dir_e dir, step_dir;
        // direction flips at the peak before stepping, so the peak level lasts exactly one period
        assign step_dir = level == sh_duty ? DIR_DOWN : level == '0 ? DIR_UP : dir;
        assign on[i] = level == MAX || pwm_cnt < level;
        always_ff @(posedge clk)
            if (rst) begin
                sh_duty <= '0;
                sh_mode <= PWM_STATIC;
                mode    <= PWM_STATIC;
                level   <= '0;
                dir     <= DIR_UP;
            end else begin
                if (cfg_wr && cfg_ch == CH_W'(i)) begin
                    sh_duty <= cfg_duty;
                    sh_mode <= pwm_mode_e'(cfg_mode);
                end
                if (boundary) begin
                    mode <= sh_mode;
                    if (sh_mode == PWM_STATIC) level <= sh_duty;
                    else if (mode == PWM_STATIC || sh_duty == '0) begin
                        level <= '0;
                        dir   <= DIR_UP;
                    end else if (level > sh_duty) begin
                        level <= sh_duty;
                        dir   <= DIR_DOWN;
                    end else begin
                        dir   <= step_dir;
                        level <= step_dir == DIR_UP ? level + 1'b1 : level - 1'b1;
                    end
                end
            end
    end
endmodule

// File: tb/tb_pwm_led_driver.sv
// tb_pwm_led_driver: scoreboard bench counting per-period high cycles of both polarities
module tb_pwm_led_driver;
    typedef struct packed {
        int         at;
        logic [1:0] ch;
        logic       mode;
        logic [3:0] duty;
    } wr_t;
    logic       clk, rst, cfg_wr, cfg_mode, period_start, period_start_n;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_duty;
    logic [2:0] led, led_n;
    int         checks, errors;
    int         exp_q[$];
    wr_t        wr_q[$];
    pwm_led_driver #(.NUM_CH(3), .RES_BITS(4), .PRESCALE(3), .ACTIVE_HIGH(1)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .led(led), .period_start(period_start)
    );
    pwm_led_driver #(.NUM_CH(3), .RES_BITS(4), .PRESCALE(3), .ACTIVE_HIGH(0)) dut_n (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .led(led_n), .period_start(period_start_n)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic push_exp(input int c0, input int c1, input int c2);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
    endtask
    task automatic push_wr(input int at, input int ch, input int mode, input int duty);
        wr_t w;
        w.at = at;
        w.ch = 2'(ch);
        w.mode = 1'(mode);
        w.duty = 4'(duty);
        wr_q.push_back(w);
    endtask
    // entered at the negedge where period_start is high; leaves at the next one
    task automatic measure(input string name);
        int hi[3];
        int lo_n[3];
        int ps_bad, e;
        wr_t w;
        for (int c = 0; c < 3; c++) begin
            hi[c] = 0;
            lo_n[c] = 0;
        end
        ps_bad = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            if (wr_q.size() > 0 && wr_q[0].at == k) begin
                w = wr_q.pop_front();
                cfg_wr = 1'b1;
                cfg_ch = w.ch;
                cfg_mode = w.mode;
                cfg_duty = w.duty;
            end
            for (int c = 0; c < 3; c++) begin
                hi[c] += int'(led[c] === 1'b1);
                lo_n[c] += int'(led_n[c] === 1'b0);
            end
            if (period_start !== 1'(k == 48)) ps_bad++;
        end
        checks++;
        if (ps_bad != 0) begin
            errors++;
            $display("FAIL %s period_start: %0d misplaced cycles, required 0", name, ps_bad);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: queue empty for ch%0d", name, c);
            end else begin
                e = exp_q.pop_front();
                if (hi[c] !== e) begin
                    errors++;
                    $display("FAIL %s ch%0d high cycles: got %0d, required %0d", name, c, hi[c], e);
                end
                checks++;
                if (lo_n[c] !== e) begin
                    errors++;
                    $display("FAIL %s ch%0d active-low on cycles: got %0d, required %0d", name, c, lo_n[c], e);
                end
            end
        end
    endtask
    // called with rst high at a negedge; releases it, writes ch0 duty 4 and checks the first period stays dark
    task automatic release_first_period(input string name);
        int n, h;
        n = 0;
        h = 0;
        rst = 1'b0;
        cfg_wr = 1'b1;
        cfg_ch = 2'd0;
        cfg_mode = 1'b0;
        cfg_duty = 4'd4;
        do begin
            @(negedge clk);
            cfg_wr = 1'b0;
            n++;
            if (led !== 3'b000 || led_n !== 3'b111) h++;
        end while (period_start !== 1'b1 && n < 200);
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL %s first period length: got %0d, required 48", name, n);
        end
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL %s first period lit cycles: got %0d, required 0", name, h);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        cfg_wr = 1'b0;
        cfg_ch = 2'd0;
        cfg_mode = 1'b0;
        cfg_duty = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL reset led: got %b, required 000", led);
        end
        checks++;
        if (led_n !== 3'b111) begin
            errors++;
            $display("FAIL reset led active-low: got %b, required 111", led_n);
        end
        checks++;
        if (period_start !== 1'b0 || dut.pwm_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset counters: period_start %b pwm_cnt %0d, required 0 0", period_start, dut.pwm_cnt);
        end
        release_first_period("reset");
    endtask
    task automatic test_static();
        push_exp(12, 0, 0);
        measure("static0");
        push_exp(12, 0, 0);
        measure("static1");
    endtask
    task automatic test_extremes();
        push_wr(10, 1, 0, 15);
        push_exp(12, 0, 0);
        measure("duty0");
        push_exp(12, 48, 0);
        measure("duty15_a");
        push_wr(5, 1, 0, 0);
        push_exp(12, 48, 0);
        measure("duty15_b");
    endtask
    task automatic test_back_to_back();
        push_wr(20, 0, 0, 8);
        push_exp(12, 0, 0);
        measure("mid_write");
        push_wr(47, 0, 0, 2);
        push_exp(24, 0, 0);
        measure("after_mid");
        push_exp(24, 0, 0);
        measure("boundary_write");
        push_wr(3, 0, 0, 10);
        push_wr(30, 0, 0, 4);
        push_exp(6, 0, 0);
        measure("after_boundary");
        push_exp(12, 0, 0);
        measure("last_wins");
    endtask
    task automatic test_breathe();
        int seq[14] = '{0, 3, 6, 9, 6, 3, 0, 3, 6, 9, 3, 0, 3, 0};
        push_wr(10, 2, 1, 3);
        push_exp(12, 0, 0);
        measure("breathe_setup");
        for (int p = 0; p < 14; p++) begin
            if (p == 9) push_wr(10, 2, 1, 1);
            if (p == 13) push_wr(5, 2, 0, 0);
            push_exp(12, 0, seq[p]);
            measure($sformatf("breathe_p%0d", p + 1));
        end
    endtask
    task automatic test_out_of_range();
        push_wr(10, 3, 0, 9);
        push_exp(12, 0, 0);
        measure("oob_a");
        push_exp(12, 0, 0);
        measure("oob_b");
    endtask
    task automatic test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid pre led: got %b, required 001", led);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (led !== 3'b000 || led_n !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid led: got %b/%b, required 000/111", led, led_n);
        end
        checks++;
        if (dut.pwm_cnt !== 4'd0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid counters: pwm_cnt %0d period_start %b, required 0 0", dut.pwm_cnt, period_start);
        end
        release_first_period("reset_mid");
        push_exp(12, 0, 0);
        measure("after_reset_mid");
    endtask
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_static();
        test_extremes();
        test_back_to_back();
        test_breathe();
        test_out_of_range();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: %0d expected, %0d writes, required 0 0", exp_q.size(), wr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
